// File: rtl/dpram_stream_ctrl.sv
// Streaming FIFO front-end that owns both ports of an external dual-port RAM.
// Define DPRAM_STREAM_CTRL_STATUS_EN to add the level and sticky overflow outputs.
module dpram_stream_ctrl #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 ram_cs,
  output logic                 ram_we,
  output logic                 ram_re,
  output logic                 ram_oe,
  output logic [ADDR_SIZE-1:0] ram_wr_address,
  output logic [ADDR_SIZE-1:0] ram_rd_address,
  output logic [DATA_SIZE-1:0] ram_data_in,
  input  logic [DATA_SIZE-1:0] ram_data_out
`ifdef DPRAM_STREAM_CTRL_STATUS_EN
  ,
  output logic [ADDR_SIZE:0]   level,
  output logic                 overflow
`endif
);

  localparam int PW = ADDR_SIZE + 1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FETCH,
    S_VALID
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] occ;

  logic [DATA_SIZE-1:0] out_data_q, out_data_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d;
  logic [ADDR_SIZE-1:0] waddr_q, waddr_d;

  logic full;
  logic have_data;
  logic wr_fire;
  logic rd_issue;

  assign occ       = wr_ptr_q - rd_ptr_q;
  assign full      = (occ == PW'(DEPTH));
  assign have_data = (occ != '0);
  assign in_ready  = !full;
  assign wr_fire   = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    rd_issue   = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (have_data) begin
          rd_issue = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        out_data_d = ram_data_out;
        state_d    = S_VALID;
      end
      S_VALID: begin
        if (out_ready) begin
          if (have_data) begin
            rd_issue = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_EMPTY;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign wr_ptr_d = wr_ptr_q + PW'(wr_fire);
  assign rd_ptr_d = rd_ptr_q + PW'(rd_issue);
  assign waddr_d  = wr_fire ? wr_ptr_q[ADDR_SIZE-1:0] : waddr_q;
  assign wdata_d  = wr_fire ? in_data : wdata_q;

  // Write address/data hold their last value between writes.
  assign ram_we         = wr_fire;
  assign ram_re         = rd_issue;
  assign ram_oe         = rd_issue;
  assign ram_cs         = wr_fire | rd_issue;
  assign ram_wr_address = waddr_d;
  assign ram_data_in    = wdata_d;
  assign ram_rd_address = rd_ptr_q[ADDR_SIZE-1:0];

  assign out_valid = (state_q == S_VALID);
  assign out_data  = out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_data_q <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_data_q <= out_data_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

`ifdef DPRAM_STREAM_CTRL_STATUS_EN
  logic overflow_q, overflow_d;

  assign overflow_d = overflow_q | (in_valid & ~in_ready);
  assign overflow   = overflow_q;
  assign level      = occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end
`endif

endmodule

// File: tb/tb_dpram_stream_ctrl.sv
// Directed bench for dpram_stream_ctrl with a behavioural dual-port RAM.
// Status-port checks run when DPRAM_STREAM_CTRL_STATUS_EN is defined.
module tb_dpram_stream_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_re;
  logic          ram_oe;
  logic [AW-1:0] ram_wr_address;
  logic [AW-1:0] ram_rd_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
`ifdef DPRAM_STREAM_CTRL_STATUS_EN
  logic [AW:0]   level;
  logic          overflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_stream_ctrl #(
    .ADDR_SIZE(AW),
    .DATA_SIZE(DW),
    .DEPTH(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .ram_cs(ram_cs),
    .ram_we(ram_we),
    .ram_re(ram_re),
    .ram_oe(ram_oe),
    .ram_wr_address(ram_wr_address),
    .ram_rd_address(ram_rd_address),
    .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
`ifdef DPRAM_STREAM_CTRL_STATUS_EN
    ,
    .level(level),
    .overflow(overflow)
`endif
  );

  // External RAM: registered read, data valid after the read edge.
  logic [DW-1:0] mem [D];
  logic [DW-1:0] rd_q;

  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_wr_address] <= ram_data_in;
    if (ram_cs && ram_re) rd_q <= mem[ram_rd_address];
  end

  assign ram_data_out = rd_q;

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if ({ram_cs, ram_we, ram_re, ram_oe} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0000",
               {ram_cs, ram_we, ram_re, ram_oe});
    end
    checks++;
    if ({ram_wr_address, ram_rd_address} !== 8'h00) begin
      errors++;
      $display("FAIL reset_addr: got %h/%h expected 0/0",
               ram_wr_address, ram_rd_address);
    end
    checks++;
    if ({ram_data_in, out_data} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h/%h expected 00/00",
               ram_data_in, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, ram_cs, ram_re} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 1000",
               {in_ready, out_valid, ram_cs, ram_re});
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    #1;
    checks++;
    if ({ram_we, ram_cs, ram_re} !== 3'b110) begin
      errors++;
      $display("FAIL single_write_strobe: got %b expected 110",
               {ram_we, ram_cs, ram_re});
    end
    checks++;
    if ({ram_wr_address, ram_data_in} !== {4'h0, 8'h5A}) begin
      errors++;
      $display("FAIL single_write_addr_data: got %h/%h expected 0/5a",
               ram_wr_address, ram_data_in);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({ram_re, ram_oe, ram_cs, ram_we} !== 4'b1110) begin
      errors++;
      $display("FAIL single_read_strobe: got %b expected 1110",
               {ram_re, ram_oe, ram_cs, ram_we});
    end
    checks++;
    if (ram_rd_address !== 4'h0) begin
      errors++;
      $display("FAIL single_read_addr: got %h expected 0", ram_rd_address);
    end
    checks++;
    if ({ram_wr_address, ram_data_in} !== {4'h0, 8'h5A}) begin
      errors++;
      $display("FAIL single_write_hold: got %h/%h expected 0/5a",
               ram_wr_address, ram_data_in);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, ram_re} !== 2'b00) begin
      errors++;
      $display("FAIL single_fetch_cycle: got %b expected 00",
               {out_valid, ram_re});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL single_out: got valid=%b data=%h expected 1/5a",
               out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_consumed: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_fill();
    int idx;
    out_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_accept[%0d]: got %b expected 1", i, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got in_ready=%b expected 0", in_ready);
    end
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h01}) begin
      errors++;
      $display("FAIL fill_out_hold: got %b/%h expected 1/01",
               out_valid, out_data);
    end
`ifdef DPRAM_STREAM_CTRL_STATUS_EN
    checks++;
    if ({level, overflow} !== {5'd16, 1'b0}) begin
      errors++;
      $display("FAIL fill_level: got %0d/%b expected 16/0",
               level, overflow);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({level, overflow} !== {5'd16, 1'b1}) begin
      errors++;
      $display("FAIL fill_overflow: got %0d/%b expected 16/1",
               level, overflow);
    end
`endif
    @(negedge clk);
    out_ready = 1'b1;
    idx = 1;
    for (int c = 0; c < 100 && idx <= 17; c++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (out_data !== 8'(idx)) begin
          errors++;
          $display("FAIL fill_drain[%0d]: got %h expected %h",
                   idx, out_data, 8'(idx));
        end
        idx++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    checks++;
    if (idx !== 18) begin
      errors++;
      $display("FAIL fill_drain_count: got %0d words expected 17", idx - 1);
    end
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL fill_empty: got %b expected 01", {out_valid, in_ready});
    end
`ifdef DPRAM_STREAM_CTRL_STATUS_EN
    checks++;
    if ({level, overflow} !== {5'd0, 1'b1}) begin
      errors++;
      $display("FAIL overflow_sticky: got %0d/%b expected 0/1",
               level, overflow);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp;
    logic [AW-1:0] prev_wa;
    int sent = 0;
    int got = 0;
    int wraps = 0;
    bit have_prev = 0;
    for (int c = 0; c < 600 && got < 40; c++) begin
      @(negedge clk);
      in_valid  = (sent < 40);
      in_data   = 8'(sent * 7 + 3);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        sent++;
        checks++;
        if (ram_we !== 1'b1 || ram_data_in !== in_data) begin
          errors++;
          $display("FAIL b2b_write[%0d]: got we=%b data=%h expected 1/%h",
                   sent, ram_we, ram_data_in, in_data);
        end
        if (have_prev && prev_wa == 4'hF && ram_wr_address == 4'h0)
          wraps++;
        prev_wa   = ram_wr_address;
        have_prev = 1;
      end
      if (out_valid && out_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        checks++;
        if (out_data !== exp) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got %h expected %h",
                   got, out_data, exp);
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got !== 40) begin
      errors++;
      $display("FAIL b2b_count: got %0d words expected 40", got);
    end
    checks++;
    if (wraps < 2) begin
      errors++;
      $display("FAIL b2b_wrap: got %0d wraps expected >=2", wraps);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(8'h11 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h11}) begin
      errors++;
      $display("FAIL mid_pre: got %b/%h expected 1/11", out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, ram_cs, ram_re, out_data} !== {4'b0100, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset: got %b/%h expected 0100/00",
               {out_valid, in_ready, ram_cs, ram_re}, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hAB;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (out_valid) begin
        n++;
        checks++;
        if (out_data !== 8'hAB) begin
          errors++;
          $display("FAIL mid_after: got %h expected ab", out_data);
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL mid_count: got %0d words expected 1", n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
